// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers and default sizing for the asynchronous FIFO.
// Gray/binary conversions work on a fixed-size word and only honour the low w bits.
package async_fifo_pkg;

  localparam int ASIZE_DEF = 4;
  localparam int OCW_DEF   = 8;
  localparam int PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input ptr_word_t v, input int w);
    ptr_word_t r;
    r = '0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      r[i] = (i < w) ? v[i] : 1'b0;
    end
    return r;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b, input int w);
    ptr_word_t m;
    m = width_mask(b, w);
    return m ^ (m >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g, input int w);
    ptr_word_t m;
    ptr_word_t b;
    m = width_mask(g, w);
    b = '0;
    b[PTR_W_MAX-1] = m[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ m[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ch.sv
// One write-side FIFO channel: binary/Gray pointer, full and hysteretic
// near-full flags, occupancy, sticky overflow and saturating reject counter.
module wptr_full_ch
  import async_fifo_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF,
  parameter int OCW   = OCW_DEF
) (
  input  logic             wclk_i,
  input  logic             wrst_i,
  input  logic             winc_i,
  input  logic             wptr_clr_i,
  input  logic             ovf_clr_i,
  input  logic [ASIZE:0]   nf_hi_i,
  input  logic [ASIZE:0]   nf_lo_i,
  input  logic [ASIZE:0]   sync_rptr_i,
  output logic [ASIZE:0]   wptr_o,
  output logic [ASIZE-1:0] waddr_o,
  output logic [ASIZE:0]   wlevel_o,
  output logic             full_o,
  output logic             near_full_o,
  output logic             over_flow_o,
  output logic [OCW-1:0]   ovf_cnt_o
);

  localparam int PW = ASIZE + 1;

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wgray_q, wgray_d;
  logic [ASIZE:0] level_q, level_d;
  logic [ASIZE:0] rbin;
  logic           full_q, full_d;
  logic           nf_q, nf_d;
  logic           ovf_q, ovf_d;
  logic [OCW-1:0] cnt_q, cnt_d;
  logic           acc, rej;

  assign acc  = winc_i & ~full_q;
  assign rej  = winc_i & full_q;
  assign rbin = PW'(gray2bin(PTR_W_MAX'(sync_rptr_i), PW));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    wbin_d  = wbin_q + PW'(acc);
    wgray_d = PW'(bin2gray(PTR_W_MAX'(wbin_d), PW));
    level_d = wbin_d - rbin;
    // Full when the pointers differ by exactly one lap: top two Gray bits flipped.
    full_d  = (wgray_d == {~sync_rptr_i[ASIZE:ASIZE-1], sync_rptr_i[ASIZE-2:0]});

    nf_d = nf_q;
    if (full_d)                  nf_d = 1'b0;
    else if (level_d >= nf_hi_i) nf_d = 1'b1;
    else if (level_d <= nf_lo_i) nf_d = 1'b0;

    ovf_d = rej | (ovf_q & ~ovf_clr_i);

    cnt_d = cnt_q;
    if (ovf_clr_i)                 cnt_d = OCW'(rej);
    else if (rej && cnt_q != '1)   cnt_d = cnt_q + OCW'(1);
  end

  // Reset and per-channel clear both return the channel to its empty state.
  always_ff @(posedge wclk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wrst_i || wptr_clr_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      nf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      nf_q    <= nf_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wptr_o      = wgray_q;
  assign waddr_o     = wbin_q[ASIZE-1:0];
  assign wlevel_o    = level_q;
  assign full_o      = full_q;
  assign near_full_o = nf_q;
  assign over_flow_o = ovf_q;
  assign ovf_cnt_o   = cnt_q;

endmodule

// File: rtl/wptr_full_mc.sv
// Multi-channel write-side pointer/flag engine: one wptr_full_ch per channel,
// with the top level only slicing the packed buses.
module wptr_full_mc
  import async_fifo_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF,
  parameter int NCH   = 4,
  parameter int OCW   = OCW_DEF
) (
  input  logic                   wclk,
  input  logic                   wrst,
  input  logic [NCH-1:0]         winc,
  input  logic [NCH-1:0]         wptr_clr,
  input  logic [NCH-1:0]         ovf_clr,
  input  logic [ASIZE:0]         nf_hi,
  input  logic [ASIZE:0]         nf_lo,
  input  logic [NCH*(ASIZE+1)-1:0] sync_rptr,
  output logic [NCH*(ASIZE+1)-1:0] wptr,
  output logic [NCH*ASIZE-1:0]   waddr,
  output logic [NCH*(ASIZE+1)-1:0] wlevel,
  output logic [NCH-1:0]         full,
  output logic [NCH-1:0]         near_full,
  output logic [NCH-1:0]         over_flow,
  output logic [NCH*OCW-1:0]     ovf_cnt
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wptr_full_ch #(
      .ASIZE (ASIZE),
      .OCW   (OCW)
    ) u_ch (
      .wclk_i      (wclk),
      .wrst_i      (wrst),
      .winc_i      (winc[c]),
      .wptr_clr_i  (wptr_clr[c]),
      .ovf_clr_i   (ovf_clr[c]),
      .nf_hi_i     (nf_hi),
      .nf_lo_i     (nf_lo),
      .sync_rptr_i (sync_rptr[c*(ASIZE+1) +: ASIZE+1]),
      .wptr_o      (wptr[c*(ASIZE+1) +: ASIZE+1]),
      .waddr_o     (waddr[c*ASIZE +: ASIZE]),
      .wlevel_o    (wlevel[c*(ASIZE+1) +: ASIZE+1]),
      .full_o      (full[c]),
      .near_full_o (near_full[c]),
      .over_flow_o (over_flow[c]),
      .ovf_cnt_o   (ovf_cnt[c*OCW +: OCW])
    );
  end

endmodule

// File: tb/tb_wptr_full_mc.sv
// Scoreboard bench for wptr_full_mc: directed scenarios then random traffic,
// expectations from an occupancy-count model, checked by a separate monitor.
module tb_wptr_full_mc;

  localparam int ASIZE = 4;
  localparam int NCH   = 4;
  localparam int OCW   = 8;
  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int CMAX  = 255;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [NCH-1:0]    winc, wptr_clr, ovf_clr;
  logic [PW-1:0]     nf_hi, nf_lo;
  logic [NCH*PW-1:0] sync_rptr;
  logic [NCH*PW-1:0] wptr, wlevel;
  logic [NCH*ASIZE-1:0] waddr;
  logic [NCH-1:0]    full, near_full, over_flow;
  logic [NCH*OCW-1:0] ovf_cnt;

  always #5 wclk = ~wclk;

  wptr_full_mc #(.ASIZE(ASIZE), .NCH(NCH), .OCW(OCW)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wptr_clr  (wptr_clr),
    .ovf_clr   (ovf_clr),
    .nf_hi     (nf_hi),
    .nf_lo     (nf_lo),
    .sync_rptr (sync_rptr),
    .wptr      (wptr),
    .waddr     (waddr),
    .wlevel    (wlevel),
    .full      (full),
    .near_full (near_full),
    .over_flow (over_flow),
    .ovf_cnt   (ovf_cnt)
  );

  typedef struct packed {
    logic [NCH*PW-1:0]    wptr;
    logic [NCH*ASIZE-1:0] waddr;
    logic [NCH*PW-1:0]    wlevel;
    logic [NCH-1:0]       full;
    logic [NCH-1:0]       near_full;
    logic [NCH-1:0]       over_flow;
    logic [NCH*OCW-1:0]   ovf_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: write count and read count per channel, plain integers.
  int m_w[NCH], m_r[NCH], m_lev[NCH], m_cnt[NCH];
  bit m_full[NCH], m_nf[NCH], m_ovf[NCH];
  int hi_v = 12;
  int lo_v = 8;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Drive one cycle's inputs (called at negedge), advance the model, queue the
  // expected post-edge outputs, and return at the following negedge.
  task automatic cycle(input logic [NCH-1:0] inc, input logic [NCH-1:0] clr,
                       input logic [NCH-1:0] oclr, input logic rst);
    exp_t e;
    bit   acc, rej;
    wrst     = rst;
    winc     = inc;
    wptr_clr = clr;
    ovf_clr  = oclr;
    nf_hi    = PW'(hi_v);
    nf_lo    = PW'(lo_v);
    for (int c = 0; c < NCH; c++) sync_rptr[c*PW +: PW] = PW'(to_gray(m_r[c]));
    for (int c = 0; c < NCH; c++) begin
      if (rst || clr[c]) begin
        m_w[c] = 0; m_lev[c] = 0; m_full[c] = 0; m_nf[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
      end else begin
        acc = inc[c] && !m_full[c];
        rej = inc[c] && m_full[c];
        m_w[c]    = (m_w[c] + (acc ? 1 : 0)) % PMOD;
        m_lev[c]  = (m_w[c] - m_r[c] + PMOD) % PMOD;
        m_full[c] = (m_lev[c] == DEPTH);
        if (m_full[c])           m_nf[c] = 0;
        else if (m_lev[c] >= hi_v) m_nf[c] = 1;
        else if (m_lev[c] <= lo_v) m_nf[c] = 0;
        if (rej)       m_ovf[c] = 1;
        else if (oclr[c]) m_ovf[c] = 0;
        if (oclr[c])   m_cnt[c] = rej ? 1 : 0;
        else if (rej && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
      end
      e.wptr[c*PW +: PW]       = PW'(to_gray(m_w[c]));
      e.waddr[c*ASIZE +: ASIZE] = ASIZE'(m_w[c] % DEPTH);
      e.wlevel[c*PW +: PW]     = PW'(m_lev[c]);
      e.full[c]                = m_full[c];
      e.near_full[c]           = m_nf[c];
      e.over_flow[c]           = m_ovf[c];
      e.ovf_cnt[c*OCW +: OCW]  = OCW'(m_cnt[c]);
    end
    sb_q.push_back(e);
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic writes(input logic [NCH-1:0] inc, input int n);
    for (int i = 0; i < n; i++) cycle(inc, '0, '0, 1'b0);
  endtask

  // Monitor: every edge has a registered output set to compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int c = 0; c < NCH; c++) begin
          check($sformatf("ch%0d wptr", c), int'(wptr[c*PW +: PW]), int'(e.wptr[c*PW +: PW]));
          check($sformatf("ch%0d waddr", c), int'(waddr[c*ASIZE +: ASIZE]), int'(e.waddr[c*ASIZE +: ASIZE]));
          check($sformatf("ch%0d wlevel", c), int'(wlevel[c*PW +: PW]), int'(e.wlevel[c*PW +: PW]));
          check($sformatf("ch%0d full", c), int'(full[c]), int'(e.full[c]));
          check($sformatf("ch%0d near_full", c), int'(near_full[c]), int'(e.near_full[c]));
          check($sformatf("ch%0d over_flow", c), int'(over_flow[c]), int'(e.over_flow[c]));
          check($sformatf("ch%0d ovf_cnt", c), int'(ovf_cnt[c*OCW +: OCW]), int'(e.ovf_cnt[c*OCW +: OCW]));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [NCH-1:0] inc, clr, oclr;
    int             room;
    for (int c = 0; c < NCH; c++) m_r[c] = 0;

    // Reset with writes requested on every channel.
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    check("reset wptr", int'(wptr), 0);
    check("reset wlevel", int'(wlevel), 0);
    check("reset flags", int'({full, near_full, over_flow}), 0);
    check("reset ovf_cnt", int'(ovf_cnt), 0);

    // Fill channel 0 to full, then one rejected write.
    writes(4'b0001, 16);
    check("fill full0", int'(full[0]), 1);
    check("fill wptr0", int'(wptr[0 +: PW]), 5'b11000);
    check("fill wlevel0", int'(wlevel[0 +: PW]), 16);
    check("fill waddr0", int'(waddr[0 +: ASIZE]), 0);
    writes(4'b0001, 1);
    check("reject wptr0", int'(wptr[0 +: PW]), 5'b11000);
    check("reject over_flow0", int'(over_flow[0]), 1);
    check("reject ovf_cnt0", int'(ovf_cnt[0 +: OCW]), 1);
    cycle(4'b0000, 4'b0001, 4'b0000, 1'b0);

    // Near-full hysteresis with hi=12, lo=8.
    writes(4'b0001, 12);
    check("hyst set", int'(near_full[0]), 1);
    m_r[0] = 3;
    writes(4'b0000, 1);
    check("hyst level9", int'(wlevel[0 +: PW]), 9);
    check("hyst hold", int'(near_full[0]), 1);
    m_r[0] = 4;
    writes(4'b0000, 1);
    check("hyst clear", int'(near_full[0]), 0);
    writes(4'b0001, 4);
    check("hyst reset", int'(near_full[0]), 1);
    m_r[0] = 0;
    cycle(4'b0000, 4'b0001, 4'b0000, 1'b0);

    // Wrap on channel 1: wbin 31 with rptr 16, then one more write.
    writes(4'b0010, 16);
    m_r[1] = 16;
    writes(4'b0000, 1);
    writes(4'b0010, 15);
    check("wrap level15", int'(wlevel[PW +: PW]), 15);
    writes(4'b0010, 1);
    check("wrap wptr1", int'(wptr[PW +: PW]), 0);
    check("wrap waddr1", int'(waddr[ASIZE +: ASIZE]), 0);
    check("wrap wlevel1", int'(wlevel[PW +: PW]), 16);
    check("wrap full1", int'(full[1]), 1);

    // Channel 2 cleared while channel 0 writes in the same cycle.
    writes(4'b0100, 16);
    check("ch2 full", int'(full[2]), 1);
    cycle(4'b0101, 4'b0100, 4'b0000, 1'b0);
    check("clr wptr2", int'(wptr[2*PW +: PW]), 0);
    check("clr full2", int'(full[2]), 0);
    check("clr wlevel2", int'(wlevel[2*PW +: PW]), 0);
    check("clr ch0 advance", int'(wlevel[0 +: PW]), 1);
    check("clr ch1 unchanged", int'(wlevel[PW +: PW]), 16);

    // Overflow clear semantics on channel 3.
    writes(4'b1000, 16);
    cycle(4'b1000, 4'b0000, 4'b1000, 1'b0);
    check("oclr+rej over_flow3", int'(over_flow[3]), 1);
    check("oclr+rej ovf_cnt3", int'(ovf_cnt[3*OCW +: OCW]), 1);
    writes(4'b1000, 300);
    check("ovf saturate", int'(ovf_cnt[3*OCW +: OCW]), 255);
    cycle(4'b0000, 4'b0000, 4'b1000, 1'b0);
    check("oclr over_flow3", int'(over_flow[3]), 0);
    check("oclr ovf_cnt3", int'(ovf_cnt[3*OCW +: OCW]), 0);

    // Random traffic with plausible read-pointer motion and varied thresholds.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        hi_v = $urandom_range(0, 17);
        lo_v = $urandom_range(0, 17);
      end
      inc  = NCH'($urandom);
      clr  = ($urandom_range(0, 39) == 0) ? NCH'($urandom) : '0;
      oclr = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      for (int c = 0; c < NCH; c++) begin
        if (clr[c]) m_r[c] = 0;
        else if ($urandom_range(0, 2) == 0) begin
          room   = (m_w[c] - m_r[c] + PMOD) % PMOD;
          m_r[c] = (m_r[c] + $urandom_range(0, room)) % PMOD;
        end
      end
      cycle(inc, clr, oclr, 1'b0);
    end

    repeat (3) @(negedge wclk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
